// File: rtl/cond_pkg.sv
// cond_pkg: ARM condition codes and NZCV flag positions shared by the conditional-execution unit
package cond_pkg;
  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_e;
  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;
endpackage

// File: rtl/cond_check.sv
// cond_check: combinational evaluation of an ARM condition field against NZCV flags
module cond_check import cond_pkg::*; #(
  parameter bit ALWAYS_1111 = 1'b1
) (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       met
);
  logic n, z, c, v;
  assign n = flags[N_IDX];
  assign z = flags[Z_IDX];
  assign c = flags[C_IDX];
  assign v = flags[V_IDX];
  always_comb begin
    case (cond_e'(cond))
      EQ: met = z;
      NE: met = ~z;
      CS: met = c;
      CC: met = ~c;
      MI: met = n;
      PL: met = ~n;
      VS: met = v;
      VC: met = ~v;
      HI: met = c & ~z;
      LS: met = ~c | z;
      GE: met = n == v;
      LT: met = n != v;
      GT: met = ~z & (n == v);
      LE: met = z | (n != v);
      AL: met = 1'b1;
      NV: met = ALWAYS_1111;
      default: met = 1'b0;
    endcase
  end
endmodule

// File: rtl/cond_logic_pipe.sv
// cond_logic_pipe: E-stage flags register and condition gating, with gated controls carried through E/M and M/W
module cond_logic_pipe import cond_pkg::*; #(
  parameter int NFLAGS      = 4,
  parameter bit ALWAYS_1111 = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        CondE,
  input  logic [NFLAGS-1:0] ALUFlagsE,
  input  logic [1:0]        FlagWriteE,
  input  logic              PCSrcE,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              MemtoRegE,
  input  logic              BranchE,
  input  logic              FlushE,
  output logic              CondExE,
  output logic              BranchTakenE,
  output logic [NFLAGS-1:0] FlagsQ,
  output logic              PCSrcM,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic              MemtoRegM,
  output logic              PCSrcW,
  output logic              RegWriteW,
  output logic              MemtoRegW
);
  logic met;
  cond_check #(.ALWAYS_1111(ALWAYS_1111)) u_check (
    .cond  (CondE),
    .flags (FlagsQ),
    .met   (met)
  );
  assign CondExE      = met & ~FlushE;
  assign BranchTakenE = BranchE & CondExE;
  // condition is judged on the stored flags, so a flag-setter's result is visible to the next instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      FlagsQ    <= '0;
      PCSrcM    <= 1'b0;
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
      MemtoRegM <= 1'b0;
      PCSrcW    <= 1'b0;
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
    end else begin
      if (FlagWriteE[1] & CondExE) FlagsQ[N_IDX:Z_IDX] <= ALUFlagsE[N_IDX:Z_IDX];
      if (FlagWriteE[0] & CondExE) FlagsQ[C_IDX:V_IDX] <= ALUFlagsE[C_IDX:V_IDX];
      PCSrcM    <= PCSrcE & CondExE;
      RegWriteM <= RegWriteE & CondExE;
      MemWriteM <= MemWriteE & CondExE;
      MemtoRegM <= MemtoRegE;
      PCSrcW    <= PCSrcM;
      RegWriteW <= RegWriteM;
      MemtoRegW <= MemtoRegM;
    end
  end
endmodule

// File: tb/tb_cond_logic_pipe.sv
// tb_cond_logic_pipe: directed and randomized checks of cond_logic_pipe against a behavioural model
module tb_cond_logic_pipe;
  logic clk = 1'b0, reset;
  logic [3:0] CondE, ALUFlagsE, FlagsQ;
  logic [1:0] FlagWriteE;
  logic PCSrcE, RegWriteE, MemWriteE, MemtoRegE, BranchE, FlushE;
  logic CondExE, BranchTakenE, PCSrcM, RegWriteM, MemWriteM, MemtoRegM, PCSrcW, RegWriteW, MemtoRegW;
  int passed = 0, total = 0;
  logic [3:0] mf;
  logic m_pc, m_rw, m_mw, m_mtr, w_pc, w_rw, w_mtr;
  localparam logic [4:0] PC = 5'b10000, RW = 5'b01000, MW = 5'b00100, MTR = 5'b00010, BR = 5'b00001;

  cond_logic_pipe dut (
    .clk(clk), .reset(reset), .CondE(CondE), .ALUFlagsE(ALUFlagsE), .FlagWriteE(FlagWriteE),
    .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
    .BranchE(BranchE), .FlushE(FlushE), .CondExE(CondExE), .BranchTakenE(BranchTakenE),
    .FlagsQ(FlagsQ), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .MemtoRegM(MemtoRegM), .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
  endtask

  // ARM rule: even codes define a base test, odd codes are its inverse; 1111 is always-true here
  function automatic logic ref_met(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, b;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cy;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cy && !z;
      3'd5: b = (n == v);
      3'd6: b = !z && (n == v);
      default: b = 1'b1;
    endcase
    return (c == 4'hF) ? 1'b1 : b ^ c[0];
  endfunction

  task automatic clear_model();
    mf = 4'h0;
    {m_pc, m_rw, m_mw, m_mtr, w_pc, w_rw, w_mtr} = '0;
  endtask

  task automatic check_regs();
    chk("flags", FlagsQ, mf);
    chk("pcsrc_m", PCSrcM, m_pc);
    chk("regwrite_m", RegWriteM, m_rw);
    chk("memwrite_m", MemWriteM, m_mw);
    chk("memtoreg_m", MemtoRegM, m_mtr);
    chk("pcsrc_w", PCSrcW, w_pc);
    chk("regwrite_w", RegWriteW, w_rw);
    chk("memtoreg_w", MemtoRegW, w_mtr);
  endtask

  // drive one instruction at a negedge, check comb outputs, then check registered state next negedge
  task automatic cyc(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] alu, input logic [4:0] ctl, input logic fl);
    logic ce;
    CondE = c; FlagWriteE = fw; ALUFlagsE = alu; FlushE = fl;
    {PCSrcE, RegWriteE, MemWriteE, MemtoRegE, BranchE} = ctl;
    #1;
    ce = ref_met(c, mf) && !fl;
    chk("condex", CondExE, ce);
    chk("branch_taken", BranchTakenE, ctl[0] && ce);
    @(posedge clk);
    if (fw[1] && ce) mf[3:2] = alu[3:2];
    if (fw[0] && ce) mf[1:0] = alu[1:0];
    {w_pc, w_rw, w_mtr} = {m_pc, m_rw, m_mtr};
    m_pc = ctl[4] && ce; m_rw = ctl[3] && ce; m_mw = ctl[2] && ce; m_mtr = ctl[1];
    @(negedge clk);
    check_regs();
  endtask

  initial begin
    reset = 1'b0; CondE = 4'h1; ALUFlagsE = 4'hF; FlagWriteE = 2'b11;
    {PCSrcE, RegWriteE, MemWriteE, MemtoRegE, BranchE, FlushE} = '1;
    FlushE = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_regs();
    chk("reset_condex_ne", CondExE, 1'b1);
    CondE = 4'h0; #1;
    chk("reset_condex_eq", CondExE, 1'b0);
    reset = 1'b1;
    cyc(4'hE, 2'b00, 4'h0, RW, 1'b0);
    cyc(4'hE, 2'b00, 4'h0, RW, 1'b0);
    cyc(4'hE, 2'b11, 4'b0100, 5'b0, 1'b0);
    cyc(4'h0, 2'b00, 4'h0, RW, 1'b0);
    cyc(4'hE, 2'b11, 4'b0000, 5'b0, 1'b0);
    cyc(4'h0, 2'b11, 4'b1111, MW, 1'b0);
    cyc(4'hE, 2'b10, 4'b1111, 5'b0, 1'b0);
    cyc(4'hB, 2'b00, 4'h0, RW, 1'b0);
    cyc(4'hE, 2'b11, 4'b1111, PC | BR | RW, 1'b1);
    cyc(4'hE, 2'b00, 4'h0, PC | BR, 1'b0);
    cyc(4'hE, 2'b00, 4'h0, MTR, 1'b0);
    cyc(4'hF, 2'b00, 4'h0, RW, 1'b0);
    for (int i = 0; i < 400; i++)
      cyc(4'($urandom_range(0, 15)), 2'($urandom), 4'($urandom), 5'($urandom), $urandom_range(0, 3) == 0);
    cyc(4'hE, 2'b11, 4'b1010, RW | PC | MTR, 1'b0);
    cyc(4'hE, 2'b00, 4'h0, RW | PC | MTR, 1'b0);
    #2 reset = 1'b0;
    #1;
    clear_model();
    check_regs();
    @(negedge clk);
    check_regs();
    reset = 1'b1;
    cyc(4'h1, 2'b00, 4'h0, RW, 1'b0);
    cyc(4'h0, 2'b00, 4'h0, RW, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cond_logic_pipe.md
Name: cond_logic_pipe

Overview:
- Execute-stage conditional-execution unit for the 5-stage pipelined ARM core; sits directly downstream of the datapath's D/E pipeline register.
- Holds the NZCV flags register and evaluates the instruction condition field against the stored flags.
- Gates the E-stage write/branch controls with the condition result and carries the gated controls through E/M and M/W registers back into the datapath.

Parameters:
- NFLAGS, 4, width of the flags register (N,Z,C,V; bit 3 = N, bit 0 = V).
- ALWAYS_1111, 1, when 1 the cond code 4'b1111 is treated as always-true; when 0 it is never-true.

Ports:
- clk  in  1  core clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- CondE  in  4  condition field, Instr[31:28] of the instruction in E.
- ALUFlagsE  in  4  NZCV produced by the ALU this cycle.
- FlagWriteE  in  2  [1] = update N,Z; [0] = update C,V.
- PCSrcE, RegWriteE, MemWriteE, MemtoRegE, BranchE  in  1 each  ungated decode controls for the instruction in E.
- FlushE  in  1  hazard-unit squash of the instruction in E.
- CondExE  out  1  condition passed and not flushed.
- BranchTakenE  out  1  BranchE & CondExE, combinational.
- FlagsQ  out  4  current flags-register contents.
- PCSrcM, RegWriteM, MemWriteM, MemtoRegM  out  1 each  gated controls in the M stage.
- PCSrcW, RegWriteW, MemtoRegW  out  1 each  gated controls in the W stage.

Behaviour:
- Reset (reset = 0, asynchronous): FlagsQ = 4'b0000; all M- and W-stage outputs = 0. CondExE and BranchTakenE follow their combinational equations using the cleared flags.
- Condition evaluation is combinational on FlagsQ, not on ALUFlagsE.
  - EQ: Z.  NE: ~Z.  CS: C.  CC: ~C.  MI: N.  PL: ~N.  VS: V.  VC: ~V.
  - HI: C&~Z.  LS: ~C|Z.  GE: N==V.  LT: N!=V.  GT: ~Z&(N==V).  LE: Z|(N!=V).
  - AL (1110): 1.  1111: per ALWAYS_1111.
- CondExE = condition_met & ~FlushE.
- Flag update at the rising clk edge:
  - FlagsQ[3:2] <= ALUFlagsE[3:2] if FlagWriteE[1] & CondExE.
  - FlagsQ[1:0] <= ALUFlagsE[1:0] if FlagWriteE[0] & CondExE.
  - Otherwise the field holds.
- Back-to-back flag-setting instructions: the second instruction's condition sees the first instruction's flags.
- E/M register, 1-cycle latency: PCSrcM <= PCSrcE & CondExE; same gating for RegWriteM and MemWriteM. MemtoRegM <= MemtoRegE, ungated.
- M/W register, 1-cycle latency: PCSrcW <= PCSrcM; RegWriteW <= RegWriteM; MemtoRegW <= MemtoRegM.
- A failed condition or FlushE inserts a bubble: all gated controls are 0 in M one cycle later and in W two cycles later. Flags are unchanged.
- FlushE and a passing condition in the same cycle: the flush wins.
- No stall input: the E/M and M/W registers advance every cycle.
- Reset asserted mid-operation: in-flight M and W controls are cleared immediately, with no partial writes. Flags return to 0.

Decomposition:
- Shared package, cond_pkg:
  - cond_e enum with the 16 ARM condition codes (EQ = 4'h0 … AL = 4'hE, NV = 4'hF).
  - Flag index constants N_IDX = 3, Z_IDX = 2, C_IDX = 1, V_IDX = 0.
- Sub-module cond_check: purely combinational; inputs cond[3:0] and flags[3:0], output met.

Test Plan:
- Reset: reset = 0 for 2 cycles, then release; CondE = 4'hE, RegWriteE = 1 -> FlagsQ = 0000, RegWriteM = 1 one cycle later, RegWriteW = 1 two cycles later.
- Flag set then EQ test: cycle 0: CondE = E, FlagWriteE = 11, ALUFlagsE = 0100. Cycle 1: CondE = 0 (EQ), RegWriteE = 1 -> FlagsQ = 0100, CondExE = 1, RegWriteM = 1 in cycle 2.
- Failed condition: FlagsQ = 0000; CondE = 0 (EQ), MemWriteE = 1, FlagWriteE = 11, ALUFlagsE = 1111 -> CondExE = 0, MemWriteM = 0, FlagsQ stays 0000.
- Partial flag write: FlagsQ = 0000; CondE = E, FlagWriteE = 10, ALUFlagsE = 1111 -> FlagsQ = 1100. Then CondE = B (LT) -> CondExE = 1.
- Branch plus flush: BranchE = 1, PCSrcE = 1, CondE = E, FlushE = 1 -> BranchTakenE = 0, PCSrcM = 0. Same stimulus with FlushE = 0 -> BranchTakenE = 1, PCSrcM = 1, PCSrcW = 1.
- Async reset mid-flight: RegWriteM = 1 and RegWriteW = 1; drive reset low between clock edges -> both drop to 0 immediately and FlagsQ = 0000.
